// File: rtl/fm_demod_pkg.sv
// Shared definitions for the FM demodulator sample path.
//   SAMPLE_WIDTH : native signed sample width
//   clog2()      : ceiling log2 for elaboration-time parameter checks
//   rnd()        : rounding constant (one half LSB) for a right shift of LOG2 bits
package fm_demod_pkg;

    localparam int SAMPLE_WIDTH = 16;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int rnd(input int log2);
        return 1 << (log2 - 1);
    endfunction

endpackage

// File: rtl/round_shift.sv
// Combinational signed round-and-shift: dout = (din + 2^(SHIFT-1)) >>> SHIFT,
// i.e. divide by 2^SHIFT rounding half toward +inf.
//   din  : signed input, IN_WIDTH bits
//   dout : signed result, IN_WIDTH-SHIFT bits
// The caller guarantees din + half does not overflow IN_WIDTH bits.
module round_shift
    import fm_demod_pkg::*;
#(
    parameter int IN_WIDTH = 23,
    parameter int SHIFT    = 7
) (
    input  logic signed [IN_WIDTH-1:0]       din,
    output logic signed [IN_WIDTH-SHIFT-1:0] dout
);

    localparam logic signed [IN_WIDTH-1:0] HALF = IN_WIDTH'(rnd(SHIFT));

    logic signed [IN_WIDTH-1:0] biased;
    logic                       unused_lsb;

    assign biased = din + HALF;
    // Dropping the low bits of a two's-complement value is an arithmetic shift.
    assign dout       = biased[IN_WIDTH-1:SHIFT];
    assign unused_lsb = ^biased[SHIFT-1:0];

endmodule

// File: rtl/avg_dump_decim.sv
// Accumulate-and-dump decimator. Sums DECIM valid samples and emits their
// rounded mean as a one-cycle strobe.
//   clk, rst : clock, synchronous active-high reset
//   sync_i   : frame realign; drops the partial sum, restarts phase at 0
//   valid_i  : data_i qualifier, gaps allowed
//   data_i   : signed input sample
//   data_o   : rounded mean of last completed frame, held between strobes
//   valid_o  : one-cycle strobe with new data_o (feeds downstream start_i)
//   phase_o  : index of the next sample within the frame
module avg_dump_decim
    import fm_demod_pkg::*;
#(
    parameter int WIDTH      = SAMPLE_WIDTH,
    parameter int DECIM      = 128,
    parameter int LOG2_DECIM = 7
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    sync_i,
    input  logic                    valid_i,
    input  logic signed [WIDTH-1:0] data_i,
    output logic signed [WIDTH-1:0] data_o,
    output logic                    valid_o,
    output logic [LOG2_DECIM-1:0]   phase_o
);

    if (DECIM < 2 || (1 << LOG2_DECIM) != DECIM || clog2(DECIM) != LOG2_DECIM) begin : g_bad_decim
        $error("avg_dump_decim: DECIM must be a power of two >= 2 and equal 2**LOG2_DECIM");
    end

    // DECIM samples of WIDTH bits fit in WIDTH+LOG2_DECIM bits, so no overflow.
    localparam int AW = WIDTH + LOG2_DECIM;
    localparam logic [LOG2_DECIM-1:0] LAST = LOG2_DECIM'(DECIM - 1);

    logic signed [AW-1:0]         acc_r;
    logic [LOG2_DECIM-1:0]        phase_r;
    logic signed [AW-1:0]         data_ext;
    logic signed [AW-1:0]         full;
    logic signed [WIDTH-1:0]      mean;

    assign data_ext = {{LOG2_DECIM{data_i[WIDTH-1]}}, data_i};
    assign full     = acc_r + data_ext;
    assign phase_o  = phase_r;

    // Mean of a frame always lies within the sample range, so no saturation.
    round_shift #(.IN_WIDTH(AW), .SHIFT(LOG2_DECIM)) u_round (
        .din  (full),
        .dout (mean)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r   <= '0;
            phase_r <= '0;
            data_o  <= '0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            if (sync_i) begin
                // Realign wins over dump; a valid sample starts the new frame.
                acc_r   <= valid_i ? data_ext : '0;
                phase_r <= valid_i ? LOG2_DECIM'(1) : '0;
            end else if (valid_i) begin
                if (phase_r == LAST) begin
                    data_o  <= mean;
                    valid_o <= 1'b1;
                    acc_r   <= '0;
                    phase_r <= '0;
                end else begin
                    acc_r   <= full;
                    phase_r <= phase_r + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_avg_dump_decim.sv
module tb_avg_dump_decim;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               sync_i = 1'b0;
    logic               valid_i = 1'b0;
    logic signed [15:0] data_i = '0;
    logic signed [15:0] data_o;
    logic               valid_o;
    logic [1:0]         phase_o;

    int vectors = 0;
    int errors  = 0;

    avg_dump_decim #(.WIDTH(16), .DECIM(4), .LOG2_DECIM(2)) dut (
        .clk     (clk),
        .rst     (rst),
        .sync_i  (sync_i),
        .valid_i (valid_i),
        .data_i  (data_i),
        .data_o  (data_o),
        .valid_o (valid_o),
        .phase_o (phase_o)
    );

    always #5 clk = ~clk;

    // Advance one edge; outputs are sampled 1 ns after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int s);
        valid_i = 1'b1;
        data_i  = 16'(s);
        tick();
        valid_i = 1'b0;
    endtask

    // Feed a frame of four samples, checking no early strobe and the final mean.
    task automatic frame(input string name, input int s0, input int s1, input int s2,
                         input int s3, input int exp);
        int s[4];
        s = '{s0, s1, s2, s3};
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            vectors++;
            if (valid_o !== (i == 3)) begin
                errors++;
                $display("FAIL %s valid_o sample %0d: got %b want %b", name, i, valid_o, i == 3);
            end
        end
        vectors++;
        if (data_o !== 16'(exp)) begin
            errors++;
            $display("FAIL %s data_o: got %0d want %0d", name, data_o, exp);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++;
            if (data_o !== 16'sd0 || valid_o !== 1'b0 || phase_o !== 2'd0) begin
                errors++;
                $display("FAIL reset cyc %0d: data_o=%0d valid_o=%b phase_o=%0d want 0/0/0",
                         i, data_o, valid_o, phase_o);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            vectors++;
            if (data_o !== 16'sd0 || valid_o !== 1'b0 || phase_o !== 2'd0) begin
                errors++;
                $display("FAIL idle cyc %0d: data_o=%0d valid_o=%b phase_o=%0d want 0/0/0",
                         i, data_o, valid_o, phase_o);
            end
        end
    endtask

    task automatic test_back_to_back();
        valid_i = 1'b1;
        data_i  = 16'sd100;
        for (int i = 1; i <= 8; i++) begin
            tick();
            vectors++;
            if (valid_o !== (i % 4 == 0) || phase_o !== 2'(i % 4)) begin
                errors++;
                $display("FAIL b2b cyc %0d: valid_o=%b phase_o=%0d want %b/%0d",
                         i, valid_o, phase_o, i % 4 == 0, i % 4);
            end
            if (i % 4 == 0) begin
                vectors++;
                if (data_o !== 16'sd100) begin
                    errors++;
                    $display("FAIL b2b data cyc %0d: got %0d want 100", i, data_o);
                end
            end
        end
        valid_i = 1'b0;
        tick();
        vectors++;
        if (valid_o !== 1'b0 || data_o !== 16'sd100) begin
            errors++;
            $display("FAIL b2b after: valid_o=%b data_o=%0d want 0/100", valid_o, data_o);
        end
    endtask

    task automatic test_rounding();
        frame("round_p3", 1, 1, 1, 0, 1);
        frame("round_m2", -1, -1, 0, 0, 0);
        frame("round_m3", -1, -1, -1, 0, -1);
    endtask

    task automatic test_extremes();
        frame("max", 32767, 32767, 32767, 32767, 32767);
        frame("min", -32768, -32768, -32768, -32768, -32768);
    endtask

    task automatic test_gapped();
        int s[4];
        s = '{10, 20, 30, 40};
        for (int i = 0; i < 4; i++) begin
            send(s[i]);
            vectors++;
            if (valid_o !== (i == 3)) begin
                errors++;
                $display("FAIL gap strobe %0d: got %b want %b", i, valid_o, i == 3);
            end
            if (i == 3) begin
                vectors++;
                if (data_o !== 16'sd25) begin
                    errors++;
                    $display("FAIL gap data: got %0d want 25", data_o);
                end
            end
            for (int g = 0; g < 2 && i < 3; g++) begin
                tick();
                vectors++;
                if (valid_o !== 1'b0 || phase_o !== 2'(i + 1)) begin
                    errors++;
                    $display("FAIL gap idle %0d/%0d: valid_o=%b phase_o=%0d want 0/%0d",
                             i, g, valid_o, phase_o, i + 1);
                end
            end
        end
        for (int g = 0; g < 5; g++) begin
            tick();
            vectors++;
            if (valid_o !== 1'b0 || data_o !== 16'sd25) begin
                errors++;
                $display("FAIL gap hold %0d: valid_o=%b data_o=%0d want 0/25", g, valid_o, data_o);
            end
        end
    endtask

    task automatic test_sync();
        // Case 1: realign mid-frame with a valid sample.
        send(500);
        send(500);
        sync_i = 1'b1;
        send(8);
        sync_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || phase_o !== 2'd1) begin
            errors++;
            $display("FAIL sync1: valid_o=%b phase_o=%0d want 0/1", valid_o, phase_o);
        end
        send(8);
        send(8);
        send(8);
        vectors++;
        if (valid_o !== 1'b1 || data_o !== 16'sd8) begin
            errors++;
            $display("FAIL sync1 frame: valid_o=%b data_o=%0d want 1/8", valid_o, data_o);
        end
        // Sync at the last phase must not dump.
        send(7);
        send(7);
        send(7);
        sync_i = 1'b1;
        send(-20);
        sync_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || phase_o !== 2'd1 || data_o !== 16'sd8) begin
            errors++;
            $display("FAIL sync_last: valid_o=%b phase_o=%0d data_o=%0d want 0/1/8",
                     valid_o, phase_o, data_o);
        end
        // Sync without a sample clears to phase 0.
        sync_i = 1'b1;
        tick();
        sync_i = 1'b0;
        vectors++;
        if (valid_o !== 1'b0 || phase_o !== 2'd0) begin
            errors++;
            $display("FAIL sync_idle: valid_o=%b phase_o=%0d want 0/0", valid_o, phase_o);
        end
        frame("sync_after", 2, 2, 2, 3, 2);
    endtask

    task automatic test_reset_mid();
        send(1000);
        send(1000);
        send(1000);
        rst     = 1'b1;
        valid_i = 1'b1;
        data_i  = 16'sd1000;
        for (int i = 0; i < 2; i++) begin
            tick();
            vectors++;
            if (valid_o !== 1'b0 || phase_o !== 2'd0 || data_o !== 16'sd0) begin
                errors++;
                $display("FAIL mid_rst %0d: valid_o=%b phase_o=%0d data_o=%0d want 0/0/0",
                         i, valid_o, phase_o, data_o);
            end
        end
        rst     = 1'b0;
        valid_i = 1'b0;
        tick();
        vectors++;
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL mid_rst release: valid_o=%b want 0", valid_o);
        end
        frame("after_rst", -4, -4, -4, -4, -4);
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_rounding();
        test_extremes();
        test_gapped();
        test_sync();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
